// File: rtl/sdram_port_server_pkg.sv
// Shared client-protocol definitions for the SDRAM port server: command encodings,
// the client burst length and the data returned by a watchdog-aborted read.
package sdram_port_server_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_t;

  localparam int unsigned READ_BURST_LENGTH = 8;
  localparam logic [31:0] TIMEOUT_RDATA     = 32'hDEADBEEF;

endpackage

// File: rtl/sdram_port_server.sv
// Responder end of the command/burst SDRAM client protocol with a read-only priority port.
// Optional backend ack watchdog: define SDRAM_PORT_TIMEOUT_EN.
module sdram_port_server
  import sdram_port_server_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 22,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned READ_BURST_LENGTH = sdram_port_server_pkg::READ_BURST_LENGTH,
  parameter int unsigned PRI_BURST_LENGTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [1:0]            i_Command,
  input  logic [ADDR_WIDTH-1:0] i_Data_Address,
  input  logic [DATA_WIDTH-1:0] i_Data_Write,
  output logic                  o_Data_Read_Valid,
  output logic                  o_Data_Write_Done,
  output logic [DATA_WIDTH-1:0] o_Read_Data,
  output logic                  o_SDRAM_Requested,
  input  logic                  i_SDRAM_Yield,
  input  logic                  i_Pri_Req,
  input  logic [ADDR_WIDTH-1:0] i_Pri_Addr,
  output logic                  o_Pri_Grant,
  output logic                  o_Pri_Valid,
  output logic                  o_Mem_Req,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
  input  logic                  i_Mem_Ack,
  input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
  output logic                  o_Timeout_Err
);

  localparam int unsigned MAX_BURST = (READ_BURST_LENGTH > PRI_BURST_LENGTH) ?
                                      READ_BURST_LENGTH : PRI_BURST_LENGTH;
  localparam int unsigned CNT_W     = $clog2(MAX_BURST) + 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CL_ACC,
    S_CL_SETTLE,
    S_PRI_ACC,
    S_PRI_SETTLE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   pri_addr_q, pri_addr_d;
  logic                    grant_d;
  logic                    read_valid_d, write_done_d, pri_valid_d;
  logic [DATA_WIDTH-1:0]   read_data_d;
  logic                    cl_write;
  logic                    timeout_hit;
  logic                    acc_done;
  logic [DATA_WIDTH-1:0]   rdata_sel;

  // Backend signals are decoded from state so an async reset drops the access at once.
  assign cl_write    = (i_Command == CMD_WRITE);
  assign o_Mem_Req   = (state_q == S_CL_ACC) || (state_q == S_PRI_ACC);
  assign o_Mem_We    = (state_q == S_CL_ACC) && cl_write;
  assign o_Mem_Addr  = (state_q == S_CL_ACC)  ? i_Data_Address :
                       (state_q == S_PRI_ACC) ? pri_addr_q     : '0;
  assign o_Mem_Wdata = o_Mem_We ? i_Data_Write : '0;

`ifdef SDRAM_PORT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] timer_q;
  logic             err_q;

  assign timeout_hit   = o_Mem_Req && !i_Mem_Ack && (timer_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_Timeout_Err = err_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (o_Mem_Req && !i_Mem_Ack && !timeout_hit) timer_q <= timer_q + TMO_W'(1);
      else                                         timer_q <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_Timeout_Err = 1'b0;
`endif

  assign acc_done  = o_Mem_Req && (i_Mem_Ack || timeout_hit);
  assign rdata_sel = timeout_hit ? DATA_WIDTH'(TIMEOUT_RDATA) : i_Mem_Rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pri_addr_d   = pri_addr_q;
    grant_d      = o_Pri_Grant;
    read_valid_d = 1'b0;
    write_done_d = 1'b0;
    pri_valid_d  = 1'b0;
    read_data_d  = o_Read_Data;
    unique case (state_q)
      S_IDLE: begin
        if (o_SDRAM_Requested && i_SDRAM_Yield) begin
          pri_addr_d = i_Pri_Addr;
          cnt_d      = '0;
          grant_d    = 1'b1;
          state_d    = S_PRI_ACC;
        end else if (i_Command == CMD_READ || i_Command == CMD_WRITE) begin
          cnt_d   = '0;
          state_d = S_CL_ACC;
        end
      end
      S_CL_ACC: begin
        if (acc_done) begin
          if (cl_write) begin
            write_done_d = 1'b1;
          end else begin
            read_valid_d = 1'b1;
            read_data_d  = rdata_sel;
          end
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_CL_SETTLE;
        end
      end
      S_CL_SETTLE: begin
        state_d = (cnt_q == CNT_W'(READ_BURST_LENGTH)) ? S_IDLE : S_CL_ACC;
      end
      S_PRI_ACC: begin
        if (acc_done) begin
          pri_valid_d = 1'b1;
          read_data_d = rdata_sel;
          pri_addr_d  = pri_addr_q + ADDR_WIDTH'(1);
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = S_PRI_SETTLE;
        end
      end
      S_PRI_SETTLE: begin
        if (cnt_q == CNT_W'(PRI_BURST_LENGTH)) begin
          grant_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_PRI_ACC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q             <= '0;
      pri_addr_q        <= '0;
      o_Pri_Grant       <= 1'b0;
      o_SDRAM_Requested <= 1'b0;
      o_Data_Read_Valid <= 1'b0;
      o_Data_Write_Done <= 1'b0;
      o_Pri_Valid       <= 1'b0;
      o_Read_Data       <= '0;
    end else begin
      cnt_q             <= cnt_d;
      pri_addr_q        <= pri_addr_d;
      o_Pri_Grant       <= grant_d;
      o_SDRAM_Requested <= i_Pri_Req && !o_Pri_Grant;
      o_Data_Read_Valid <= read_valid_d;
      o_Data_Write_Done <= write_done_d;
      o_Pri_Valid       <= pri_valid_d;
      o_Read_Data       <= read_data_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_server.sv
// Directed self-checking bench for sdram_port_server: client bursts, priority handoff,
// address wrap, async reset mid-burst and (with SDRAM_PORT_TIMEOUT_EN) the ack watchdog.
module tb_sdram_port_server;
  import sdram_port_server_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic [1:0]  i_Command;
  logic [21:0] i_Data_Address;
  logic [31:0] i_Data_Write;
  logic        o_Data_Read_Valid, o_Data_Write_Done;
  logic [31:0] o_Read_Data;
  logic        o_SDRAM_Requested;
  logic        i_SDRAM_Yield;
  logic        i_Pri_Req;
  logic [21:0] i_Pri_Addr;
  logic        o_Pri_Grant, o_Pri_Valid;
  logic        o_Mem_Req, o_Mem_We;
  logic [21:0] o_Mem_Addr;
  logic [31:0] o_Mem_Wdata;
  logic        i_Mem_Ack;
  logic [31:0] i_Mem_Rdata;
  logic        o_Timeout_Err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [21:0] last_addr;
  logic        last_we;
  logic [31:0] last_wdata;
  bit          hold_ack = 1'b0;
  int unsigned lat      = 3;

  sdram_port_server #(
    .ADDR_WIDTH       (22),
    .DATA_WIDTH       (32),
    .READ_BURST_LENGTH(8),
    .PRI_BURST_LENGTH (16),
    .TIMEOUT_CYCLES   (255)
  ) dut (
    .i_Clk            (i_Clk),
    .i_Rst_n          (i_Rst_n),
    .i_Command        (i_Command),
    .i_Data_Address   (i_Data_Address),
    .i_Data_Write     (i_Data_Write),
    .o_Data_Read_Valid(o_Data_Read_Valid),
    .o_Data_Write_Done(o_Data_Write_Done),
    .o_Read_Data      (o_Read_Data),
    .o_SDRAM_Requested(o_SDRAM_Requested),
    .i_SDRAM_Yield    (i_SDRAM_Yield),
    .i_Pri_Req        (i_Pri_Req),
    .i_Pri_Addr       (i_Pri_Addr),
    .o_Pri_Grant      (o_Pri_Grant),
    .o_Pri_Valid      (o_Pri_Valid),
    .o_Mem_Req        (o_Mem_Req),
    .o_Mem_We         (o_Mem_We),
    .o_Mem_Addr       (o_Mem_Addr),
    .o_Mem_Wdata      (o_Mem_Wdata),
    .i_Mem_Ack        (i_Mem_Ack),
    .i_Mem_Rdata      (i_Mem_Rdata),
    .o_Timeout_Err    (o_Timeout_Err)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backend: acks on the lat-th cycle of a request, returns A5 tag ORed with the address.
  initial begin
    i_Mem_Ack   = 1'b0;
    i_Mem_Rdata = '0;
    forever begin
      int unsigned wcnt;
      @(negedge i_Clk);
      if (o_Mem_Req && !hold_ack && i_Rst_n) begin
        if (wcnt == lat - 1) begin
          i_Mem_Ack   = 1'b1;
          i_Mem_Rdata = 32'hA500_0000 | {10'd0, o_Mem_Addr};
          last_addr   = o_Mem_Addr;
          last_we     = o_Mem_We;
          last_wdata  = o_Mem_Wdata;
          wcnt        = 0;
        end else begin
          i_Mem_Ack = 1'b0;
          wcnt++;
        end
      end else begin
        i_Mem_Ack = 1'b0;
        wcnt      = 0;
      end
    end
  end

  // sel: 0 read valid, 1 write done, 2 priority valid, 3 grant
  task automatic wait_sig(input int sel, input int unsigned budget, output bit got);
    got = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      @(negedge i_Clk);
      if ((sel == 0 && o_Data_Read_Valid) || (sel == 1 && o_Data_Write_Done) ||
          (sel == 2 && o_Pri_Valid) || (sel == 3 && o_Pri_Grant)) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic client_burst(input logic [1:0] cmd, input logic [21:0] base,
                              input int unsigned words, input int unsigned pri_at);
    bit got;
    i_Data_Address = base;
    i_Data_Write   = 32'h0101_0102;
    i_Command      = cmd;
    i_SDRAM_Yield  = 1'b0;
    for (int unsigned i = 0; i < words; i++) begin
      wait_sig((cmd == CMD_WRITE) ? 1 : 0, 40, got);
      check("cl_pulse", {31'd0, got}, 32'd1);
      check("cl_mem_addr", {10'd0, last_addr}, {10'd0, base + 22'(i)});
      if (cmd == CMD_WRITE) begin
        check("cl_we", {31'd0, last_we}, 32'd1);
        check("cl_wdata", last_wdata, 32'h0101_0102 + i);
      end else begin
        check("cl_we", {31'd0, last_we}, 32'd0);
        check("cl_rdata", o_Read_Data, 32'hA500_0000 | {10'd0, base + 22'(i)});
      end
      check("cl_no_grant", {31'd0, o_Pri_Grant}, 32'd0);
      i_Data_Address = base + 22'(i + 1);
      i_Data_Write   = 32'h0101_0102 + i + 1;
      if (i + 1 == READ_BURST_LENGTH) begin
        i_Command     = CMD_IDLE;
        i_SDRAM_Yield = 1'b1;
      end
      if (pri_at != 0 && i + 1 == pri_at) begin
        i_Pri_Req = 1'b1;
        @(negedge i_Clk);
        check("requested_rise", {31'd0, o_SDRAM_Requested}, 32'd1);
      end
    end
  endtask

  task automatic pri_collect(input logic [21:0] base);
    bit got;
    wait_sig(3, 40, got);
    check("pri_grant", {31'd0, got}, 32'd1);
    for (int unsigned i = 0; i < 16; i++) begin
      wait_sig(2, 40, got);
      check("pri_pulse", {31'd0, got}, 32'd1);
      check("pri_mem_addr", {10'd0, last_addr}, {10'd0, base + 22'(i)});
      check("pri_rdata", o_Read_Data, 32'hA500_0000 | {10'd0, base + 22'(i)});
      check("pri_grant_held", {31'd0, o_Pri_Grant}, 32'd1);
      if (i == 0) i_Pri_Req = 1'b0;
    end
    @(negedge i_Clk);
    check("pri_grant_drop", {31'd0, o_Pri_Grant}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   {31'd0, o_Mem_Req}, 32'd0);
    check({tag, "_we"},    {31'd0, o_Mem_We}, 32'd0);
    check({tag, "_addr"},  {10'd0, o_Mem_Addr}, 32'd0);
    check({tag, "_wdata"}, o_Mem_Wdata, 32'd0);
    check({tag, "_rvld"},  {31'd0, o_Data_Read_Valid}, 32'd0);
    check({tag, "_wdone"}, {31'd0, o_Data_Write_Done}, 32'd0);
    check({tag, "_grant"}, {31'd0, o_Pri_Grant}, 32'd0);
    check({tag, "_pvld"},  {31'd0, o_Pri_Valid}, 32'd0);
    check({tag, "_rqst"},  {31'd0, o_SDRAM_Requested}, 32'd0);
    check({tag, "_terr"},  {31'd0, o_Timeout_Err}, 32'd0);
  endtask

  initial begin
    bit got;
    i_Rst_n        = 1'b0;
    i_Command      = CMD_IDLE;
    i_Data_Address = '0;
    i_Data_Write   = '0;
    i_SDRAM_Yield  = 1'b0;
    i_Pri_Req      = 1'b0;
    i_Pri_Addr     = '0;
    repeat (3) @(negedge i_Clk);
    check_quiet("rst");
    check("rst_rdata", o_Read_Data, 32'd0);
    i_Rst_n = 1'b1;
    repeat (2) @(negedge i_Clk);
    check_quiet("idle");

    // 1: read burst
    client_burst(CMD_READ, 22'h000100, 8, 0);
    repeat (3) @(negedge i_Clk);
    check("rd_idle_req", {31'd0, o_Mem_Req}, 32'd0);

    // 2: write burst
    client_burst(CMD_WRITE, 22'h000200, 8, 0);
    repeat (3) @(negedge i_Clk);
    check("wr_idle_req", {31'd0, o_Mem_Req}, 32'd0);

    // 3: priority request raised during client word 3, granted only after word 8
    i_Pri_Addr = 22'h017700;
    client_burst(CMD_READ, 22'h000300, 8, 3);
    pri_collect(22'h017700);
    i_SDRAM_Yield = 1'b0;
    repeat (3) @(negedge i_Clk);

    // 4: client READ and Requested&&Yield in the same IDLE cycle
    i_Pri_Addr = 22'h000400;
    i_Pri_Req  = 1'b1;
    repeat (3) @(negedge i_Clk);
    check("t4_requested", {31'd0, o_SDRAM_Requested}, 32'd1);
    check("t4_no_grant_yet", {31'd0, o_Pri_Grant}, 32'd0);
    i_Command      = CMD_READ;
    i_Data_Address = 22'h000500;
    i_SDRAM_Yield  = 1'b1;
    @(negedge i_Clk);
    check("t4_pri_first", {31'd0, o_Pri_Grant}, 32'd1);
    check("t4_mem_we", {31'd0, o_Mem_We}, 32'd0);
    check("t4_mem_addr", {10'd0, o_Mem_Addr}, 32'h0000_0400);
    i_SDRAM_Yield = 1'b0;
    pri_collect(22'h000400);
    client_burst(CMD_READ, 22'h000500, 8, 0);
    i_SDRAM_Yield = 1'b0;
    repeat (3) @(negedge i_Clk);

    // 5: priority address wraps 3FFFFF -> 0
    i_Pri_Addr    = 22'h3FFFF8;
    i_Pri_Req     = 1'b1;
    i_SDRAM_Yield = 1'b1;
    pri_collect(22'h3FFFF8);
    check("wrap_last_addr", {10'd0, last_addr}, 32'h0000_0007);
    i_SDRAM_Yield = 1'b0;
    repeat (3) @(negedge i_Clk);

    // 6: async reset during the fourth write word
    client_burst(CMD_WRITE, 22'h000600, 3, 0);
    got = 1'b0;
    for (int unsigned k = 0; k < 20 && !got; k++) begin
      @(negedge i_Clk);
      got = o_Mem_Req;
    end
    check("rst_mid_req_seen", {31'd0, got}, 32'd1);
    #2 i_Rst_n = 1'b0;
    #1;
    check_quiet("rst_mid");
    i_Command = CMD_IDLE;
    repeat (2) @(negedge i_Clk);
    check("rst_mid_no_done", {31'd0, o_Data_Write_Done}, 32'd0);
    i_Rst_n = 1'b1;
    repeat (3) @(negedge i_Clk);
    check_quiet("post_rst");
    client_burst(CMD_READ, 22'h000700, 8, 0);
    i_SDRAM_Yield = 1'b0;
    repeat (3) @(negedge i_Clk);

`ifdef SDRAM_PORT_TIMEOUT_EN
    hold_ack       = 1'b1;
    i_Data_Address = 22'h000800;
    i_Command      = CMD_READ;
    wait_sig(0, 300, got);
    check("tmo_valid", {31'd0, got}, 32'd1);
    check("tmo_err", {31'd0, o_Timeout_Err}, 32'd1);
    check("tmo_rdata", o_Read_Data, 32'hDEADBEEF);
    i_Command = CMD_IDLE;
    hold_ack  = 1'b0;
    i_Rst_n   = 1'b0;
    @(negedge i_Clk);
    check("tmo_err_clear", {31'd0, o_Timeout_Err}, 32'd0);
    i_Rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
